// File: rtl/branch_pkg.sv
// Shared types and constants for the branch execution / writeback cluster.
package branch_pkg;

  localparam int unsigned BRANCH_OP_W = 3;
  localparam int unsigned BR_XLEN     = 32;
  localparam int unsigned BR_TAG_W    = 6;

  typedef enum logic [BRANCH_OP_W-1:0] {
    OP_BEQ  = 3'd0,
    OP_BNE  = 3'd1,
    OP_BLT  = 3'd2,
    OP_BGE  = 3'd3,
    OP_BLTU = 3'd4,
    OP_BGEU = 3'd5,
    OP_JAL  = 3'd6,
    OP_JALR = 3'd7
  } branch_op_e;

  typedef struct packed {
    logic [BR_TAG_W-1:0] tag;
    logic [BR_XLEN-1:0]  result;
    logic [BR_XLEN-1:0]  jump_addr;
    logic                mispredict;
  } branch_result_t;

endpackage

// File: rtl/branch_result_fifo.sv
// In-order result buffer: single push, up to POP_W pops per cycle,
// read window exposing the oldest POP_W entries.
module branch_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned POP_W = 2,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PCW   = $clog2(POP_W + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic [PCW-1:0]         pop_cnt_i,
  output logic [CNT_W-1:0]       count_o,
  output logic                   full_o,
  output logic [POP_W*WIDTH-1:0] rd_win_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Flush wins over any same-cycle push or pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = PTR_W'((32'(head_q) + 32'(pop_cnt_i)) % DEPTH);
      tail_d  = push_i ? PTR_W'((32'(tail_q) + 32'd1) % DEPTH) : tail_q;
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_cnt_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_i && !flush_i) mem_q[tail_q] <= push_data_i;
    end
  end

  always_comb begin
    rd_win_o = '0;
    for (int unsigned i = 0; i < POP_W; i++)
      rd_win_o[i*WIDTH +: WIDTH] = mem_q[PTR_W'((32'(head_q) + i) % DEPTH)];
  end

  assign count_o = count_q;
  assign full_o  = (32'(count_q) == DEPTH);

endmodule

// File: rtl/branch_wb_cluster.sv
// Branch resolve + in-order writeback over CDB_PORTS buses with prefix grants.
// Optional BRANCH_STATS_EN adds saturating branch / mispredict counters.
module branch_wb_cluster
  import branch_pkg::*;
#(
  parameter int unsigned XLEN       = BR_XLEN,
  parameter int unsigned CDB_PORTS  = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = BR_TAG_W
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      feed_valid,
  output logic                      feed_ready,
  input  logic [BRANCH_OP_W-1:0]    feed_op,
  input  logic [XLEN-1:0]           feed_rs1,
  input  logic [XLEN-1:0]           feed_rs2,
  input  logic [XLEN-1:0]           feed_pc,
  input  logic [XLEN-1:0]           feed_imm,
  input  logic [TAG_W-1:0]          feed_tag,
  input  logic                      feed_pred_taken,
  output logic [CDB_PORTS-1:0]      cdb_req,
  input  logic [CDB_PORTS-1:0]      cdb_grant,
  output logic [CDB_PORTS-1:0]      cdb_valid,
  output logic [CDB_PORTS*TAG_W-1:0] cdb_tag,
  output logic [CDB_PORTS*XLEN-1:0] cdb_result,
  output logic [CDB_PORTS*XLEN-1:0] cdb_jump_addr,
  output logic [CDB_PORTS-1:0]      cdb_mispredict,
  output logic                      full
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]               stat_branches,
  output logic [31:0]               stat_mispredicts
`endif
);

  localparam int unsigned ENTRY_W = $bits(branch_result_t);
  localparam int unsigned PCW     = $clog2(CDB_PORTS + 1);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);

  branch_result_t              res_c;
  logic [CNT_W-1:0]            count;
  logic [CDB_PORTS*ENTRY_W-1:0] win;
  logic [PCW-1:0]              pops;
  logic                        accept;
  logic                        push;

  // Single-cycle resolve of condition, target, link and mispredict.
  always_comb begin : resolve
    logic            taken;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] target;
    branch_op_e      op;
    op     = branch_op_e'(feed_op);
    link   = feed_pc + XLEN'(4);
    target = feed_pc + feed_imm;
    taken  = 1'b0;
    case (op)
      OP_BEQ:  taken = (feed_rs1 == feed_rs2);
      OP_BNE:  taken = (feed_rs1 != feed_rs2);
      OP_BLT:  taken = ($signed(feed_rs1) <  $signed(feed_rs2));
      OP_BGE:  taken = ($signed(feed_rs1) >= $signed(feed_rs2));
      OP_BLTU: taken = (feed_rs1 <  feed_rs2);
      OP_BGEU: taken = (feed_rs1 >= feed_rs2);
      OP_JAL:  taken = 1'b1;
      OP_JALR: begin
        taken  = 1'b1;
        target = (feed_rs1 + feed_imm) & ~XLEN'(1);
      end
      default: taken = 1'b0;
    endcase
    res_c.tag        = BR_TAG_W'(feed_tag);
    res_c.result     = BR_XLEN'(((op == OP_JAL) || (op == OP_JALR)) ? link : {XLEN{1'b0}});
    res_c.jump_addr  = BR_XLEN'(taken ? target : link);
    res_c.mispredict = taken ^ feed_pred_taken;
  end

  always_comb begin
    for (int i = 0; i < int'(CDB_PORTS); i++) cdb_req[i] = (int'(count) > i);
  end

  // Only the contiguous granted prefix from bus 0 broadcasts and pops.
  always_comb begin : prefix_grant
    logic run;
    run       = !flush;
    cdb_valid = '0;
    pops      = '0;
    for (int i = 0; i < int'(CDB_PORTS); i++) begin
      cdb_valid[i] = run & cdb_req[i] & cdb_grant[i];
      run          = cdb_valid[i];
      pops         = pops + PCW'(cdb_valid[i]);
    end
  end

  assign feed_ready = !full | (pops != '0);
  assign accept     = feed_valid & feed_ready;
  assign push       = accept & !flush;

  always_comb begin : bus_data
    branch_result_t ent;
    cdb_tag        = '0;
    cdb_result     = '0;
    cdb_jump_addr  = '0;
    cdb_mispredict = '0;
    for (int unsigned i = 0; i < CDB_PORTS; i++) begin
      ent = win[i*ENTRY_W +: ENTRY_W];
      if (cdb_req[i]) begin
        cdb_tag[i*TAG_W +: TAG_W]      = TAG_W'(ent.tag);
        cdb_result[i*XLEN +: XLEN]     = XLEN'(ent.result);
        cdb_jump_addr[i*XLEN +: XLEN]  = XLEN'(ent.jump_addr);
        cdb_mispredict[i]              = ent.mispredict;
      end
    end
  end

  branch_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .POP_W (CDB_PORTS),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i       (clock),
    .rst_ni      (reset_n),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i (res_c),
    .pop_cnt_i   (pops),
    .count_o     (count),
    .full_o      (full),
    .rd_win_o    (win)
  );

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_q, stat_mispredicts_q;

  // Saturating counters; cleared only by reset, blind to flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else if (accept) begin
      if (stat_branches_q != '1) stat_branches_q <= stat_branches_q + 32'd1;
      if (res_c.mispredict && (stat_mispredicts_q != '1))
        stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_wb_cluster.sv
// Self-checking bench for branch_wb_cluster: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_branch_wb_cluster;

  localparam int XLEN  = 32;
  localparam int CDB   = 2;
  localparam int DEPTH = 4;
  localparam int TW    = 6;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              flush;
  logic              feed_valid;
  logic              feed_ready;
  logic [2:0]        feed_op;
  logic [XLEN-1:0]   feed_rs1, feed_rs2, feed_pc, feed_imm;
  logic [TW-1:0]     feed_tag;
  logic              feed_pred_taken;
  logic [CDB-1:0]    cdb_req, cdb_grant, cdb_valid, cdb_mispredict;
  logic [CDB*TW-1:0] cdb_tag;
  logic [CDB*XLEN-1:0] cdb_result, cdb_jump_addr;
  logic              full;
`ifdef BRANCH_STATS_EN
  logic [31:0]       stat_branches, stat_mispredicts;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [TW-1:0]   tag;
    logic [XLEN-1:0] res;
    logic [XLEN-1:0] jmp;
    logic            mis;
  } exp_t;

  exp_t q[$];

  always #5 clock = ~clock;

  branch_wb_cluster dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .flush           (flush),
    .feed_valid      (feed_valid),
    .feed_ready      (feed_ready),
    .feed_op         (feed_op),
    .feed_rs1        (feed_rs1),
    .feed_rs2        (feed_rs2),
    .feed_pc         (feed_pc),
    .feed_imm        (feed_imm),
    .feed_tag        (feed_tag),
    .feed_pred_taken (feed_pred_taken),
    .cdb_req         (cdb_req),
    .cdb_grant       (cdb_grant),
    .cdb_valid       (cdb_valid),
    .cdb_tag         (cdb_tag),
    .cdb_result      (cdb_result),
    .cdb_jump_addr   (cdb_jump_addr),
    .cdb_mispredict  (cdb_mispredict),
    .full            (full)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  // Reference resolve, straight from the ISA meaning of each op.
  function automatic exp_t model(input logic [2:0] op, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b, input logic [XLEN-1:0] pc,
                                 input logic [XLEN-1:0] imm, input logic [TW-1:0] tag,
                                 input logic pred);
    exp_t e;
    bit taken;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: taken = (a == b);
      3'd1: taken = (a != b);
      3'd2: taken = (sa < sb);
      3'd3: taken = (sa >= sb);
      3'd4: taken = (longint'(a) < longint'(b));
      3'd5: taken = (longint'(a) >= longint'(b));
      default: taken = 1'b1;
    endcase
    e.tag = tag;
    e.res = (op >= 3'd6) ? pc + 32'd4 : 32'd0;
    if (!taken)           e.jmp = pc + 32'd4;
    else if (op == 3'd7)  e.jmp = (a + imm) & 32'hFFFF_FFFE;
    else                  e.jmp = pc + imm;
    e.mis = taken ^ pred;
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                       input logic [TW-1:0] tag, input logic pred);
    feed_valid = 1'b1; feed_op = op; feed_rs1 = a; feed_rs2 = b;
    feed_pc = pc; feed_imm = imm; feed_tag = tag; feed_pred_taken = pred;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; flush = 1'b0; feed_valid = 1'b0; cdb_grant = '0;
    drive(3'd0, '0, '0, '0, '0, '0, 1'b0);
    feed_valid = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic push_jal(input logic [TW-1:0] tag, input logic pred);
    drive(3'd6, '0, '0, 32'(tag) * 16, 32'd8, tag, pred);
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clock);
    n_tests++;
    if ({cdb_req, cdb_valid, full, feed_ready} !== {2'b00, 2'b00, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL reset_ctl: got req=%b valid=%b full=%b ready=%b exp 00 00 0 1",
                         cdb_req, cdb_valid, full, feed_ready);
    end
    n_tests++;
    if ({cdb_tag, cdb_result, cdb_jump_addr, cdb_mispredict} !== '0) begin
      n_fail++; $display("FAIL reset_data: got tag=%h res=%h jmp=%h exp 0", cdb_tag, cdb_result, cdb_jump_addr);
    end
    // Asynchronous reset in the middle of a broadcast.
    tick();
    push_jal(6'd40, 1'b1);
    push_jal(6'd41, 1'b1);
    feed_valid = 1'b0; cdb_grant = 2'b11;
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({cdb_req, cdb_valid, full} !== 5'b0) begin
      n_fail++; $display("FAIL reset_mid: got req=%b valid=%b full=%b exp 00 00 0", cdb_req, cdb_valid, full);
    end
    tick();
    reset_n = 1'b1; cdb_grant = '0;
  endtask

  task automatic test_beq();
    apply_reset();
    drive(3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 6'd1, 1'b0);
    tick();
    feed_valid = 1'b0; cdb_grant = 2'b01;
    @(negedge clock);
    n_tests++;
    if ({cdb_req, cdb_valid} !== 4'b0101) begin
      n_fail++; $display("FAIL beq_ctl: got req=%b valid=%b exp 01 01", cdb_req, cdb_valid);
    end
    n_tests++;
    if ({cdb_tag[0 +: TW], cdb_jump_addr[0 +: XLEN], cdb_result[0 +: XLEN], cdb_mispredict[0]}
        !== {6'd1, 32'h120, 32'd0, 1'b1}) begin
      n_fail++; $display("FAIL beq_data: got tag=%0d jmp=%h res=%h mis=%b exp 1 120 0 1",
                         cdb_tag[0 +: TW], cdb_jump_addr[0 +: XLEN], cdb_result[0 +: XLEN], cdb_mispredict[0]);
    end
    tick();
    @(negedge clock);
    n_tests++;
    if (cdb_req !== 2'b00) begin
      n_fail++; $display("FAIL beq_drain: got req=%b exp 00", cdb_req);
    end
    tick();
    cdb_grant = '0;
  endtask

  task automatic test_jalr();
    drive(3'd7, 32'h1003, 32'd0, 32'h200, 32'd4, 6'd2, 1'b1);
    tick();
    feed_valid = 1'b0; cdb_grant = 2'b01;
    @(negedge clock);
    n_tests++;
    if ({cdb_valid, cdb_jump_addr[0 +: XLEN], cdb_result[0 +: XLEN], cdb_mispredict[0]}
        !== {2'b01, 32'h1006, 32'h204, 1'b0}) begin
      n_fail++; $display("FAIL jalr: got valid=%b jmp=%h res=%h mis=%b exp 01 1006 204 0",
                         cdb_valid, cdb_jump_addr[0 +: XLEN], cdb_result[0 +: XLEN], cdb_mispredict[0]);
    end
    tick();
    cdb_grant = '0;
  endtask

  task automatic test_signed();
    drive(3'd2, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 6'd3, 1'b0);
    tick();
    drive(3'd4, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h40, 6'd4, 1'b0);
    tick();
    feed_valid = 1'b0; cdb_grant = 2'b11;
    @(negedge clock);
    n_tests++;
    if ({cdb_valid, cdb_jump_addr, cdb_mispredict} !== {2'b11, 32'h404, 32'h340, 2'b01}) begin
      n_fail++; $display("FAIL blt_bltu: got valid=%b jmp1=%h jmp0=%h mis=%b exp 11 404 340 01",
                         cdb_valid, cdb_jump_addr[XLEN +: XLEN], cdb_jump_addr[0 +: XLEN], cdb_mispredict);
    end
    tick();
    cdb_grant = '0;
  endtask

  task automatic test_full();
    logic [TW-1:0] exp_tag;
    apply_reset();
    for (int i = 0; i < 4; i++) push_jal(6'(10 + i), 1'b1);
    drive(3'd6, '0, '0, 32'd14 * 16, 32'd8, 6'd14, 1'b1);
    @(negedge clock);
    n_tests++;
    if ({full, feed_ready, cdb_req} !== 4'b1011) begin
      n_fail++; $display("FAIL full_stall: got full=%b ready=%b req=%b exp 1 0 11", full, feed_ready, cdb_req);
    end
    tick();
    cdb_grant = 2'b11;
    @(negedge clock);
    n_tests++;
    if ({feed_ready, cdb_valid, cdb_tag} !== {1'b1, 2'b11, 6'd11, 6'd10}) begin
      n_fail++; $display("FAIL full_pop_push: got ready=%b valid=%b tags=%h exp 1 11 10/11",
                         feed_ready, cdb_valid, cdb_tag);
    end
    tick();
    feed_valid = 1'b0; cdb_grant = 2'b01;
    for (int i = 0; i < 3; i++) begin
      exp_tag = 6'(12 + i);
      @(negedge clock);
      n_tests++;
      if ({full, cdb_valid, cdb_tag[0 +: TW], cdb_result[0 +: XLEN]}
          !== {1'b0, 2'b01, exp_tag, 32'(exp_tag) * 16 + 32'd4}) begin
        n_fail++; $display("FAIL full_drain%0d: got full=%b valid=%b tag=%0d res=%h exp tag %0d",
                           i, full, cdb_valid, cdb_tag[0 +: TW], cdb_result[0 +: XLEN], exp_tag);
      end
      tick();
    end
    @(negedge clock);
    n_tests++;
    if (cdb_req !== 2'b00) begin
      n_fail++; $display("FAIL full_empty: got req=%b exp 00", cdb_req);
    end
    cdb_grant = '0;
  endtask

  task automatic test_prefix();
    apply_reset();
    for (int i = 0; i < 3; i++) push_jal(6'(20 + i), 1'b0);
    feed_valid = 1'b0; cdb_grant = 2'b10;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      n_tests++;
      if ({cdb_req, cdb_valid, cdb_tag[0 +: TW]} !== {2'b11, 2'b00, 6'd20}) begin
        n_fail++; $display("FAIL prefix_hold%0d: got req=%b valid=%b tag0=%0d exp 11 00 20",
                           i, cdb_req, cdb_valid, cdb_tag[0 +: TW]);
      end
      tick();
    end
    cdb_grant = 2'b11;
    @(negedge clock);
    n_tests++;
    if ({cdb_valid, cdb_tag} !== {2'b11, 6'd21, 6'd20}) begin
      n_fail++; $display("FAIL prefix_both: got valid=%b tags=%h exp 11 21/20", cdb_valid, cdb_tag);
    end
    tick();
    @(negedge clock);
    n_tests++;
    if ({cdb_req, cdb_valid, cdb_tag[0 +: TW]} !== {2'b01, 2'b01, 6'd22}) begin
      n_fail++; $display("FAIL prefix_last: got req=%b valid=%b tag0=%0d exp 01 01 22",
                         cdb_req, cdb_valid, cdb_tag[0 +: TW]);
    end
    tick();
    cdb_grant = '0;
  endtask

  task automatic test_flush();
    apply_reset();
    push_jal(6'd30, 1'b0);
    push_jal(6'd31, 1'b1);
    drive(3'd6, '0, '0, 32'h500, 32'd8, 6'd32, 1'b0);
    flush = 1'b1; cdb_grant = 2'b11;
    @(negedge clock);
    n_tests++;
    if ({cdb_req, cdb_valid} !== 4'b1100) begin
      n_fail++; $display("FAIL flush_cycle: got req=%b valid=%b exp 11 00", cdb_req, cdb_valid);
    end
    tick();
    flush = 1'b0; feed_valid = 1'b0;
    @(negedge clock);
    n_tests++;
    if ({cdb_req, cdb_valid, full} !== 5'b0) begin
      n_fail++; $display("FAIL flush_after: got req=%b valid=%b full=%b exp 00 00 0", cdb_req, cdb_valid, full);
    end
`ifdef BRANCH_STATS_EN
    n_tests++;
    if ({stat_branches, stat_mispredicts} !== {32'd3, 32'd2}) begin
      n_fail++; $display("FAIL flush_stats: got br=%0d mis=%0d exp 3 2", stat_branches, stat_mispredicts);
    end
`endif
    tick();
    cdb_grant = '0;
  endtask

  task automatic test_random();
    exp_t e;
    int pops;
    logic [CDB-1:0] exp_req, exp_valid;
    logic exp_ready, exp_full, run;
    apply_reset();
    q.delete();
    for (int c = 0; c < 600; c++) begin
      drive(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom & 32'hFFFF_FFFC,
            $urandom, 6'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) feed_rs2 = feed_rs1;
      feed_valid = ($urandom_range(0, 3) != 0);
      cdb_grant  = 2'($urandom);
      flush      = ($urandom_range(0, 19) == 0);
      @(negedge clock);
      pops = 0; run = !flush;
      for (int i = 0; i < CDB; i++) begin
        exp_req[i]   = (q.size() > i);
        exp_valid[i] = run && exp_req[i] && cdb_grant[i];
        run          = exp_valid[i];
        if (exp_valid[i]) pops++;
      end
      exp_full  = (q.size() == DEPTH);
      exp_ready = !exp_full || (pops > 0);
      n_tests++;
      if ({cdb_req, cdb_valid, full, feed_ready} !== {exp_req, exp_valid, exp_full, exp_ready}) begin
        n_fail++; $display("FAIL rand_ctl c%0d: got req=%b valid=%b full=%b ready=%b exp %b %b %b %b",
                           c, cdb_req, cdb_valid, full, feed_ready, exp_req, exp_valid, exp_full, exp_ready);
      end
      for (int i = 0; i < CDB; i++) begin
        if (exp_req[i]) begin
          e = q[i];
          n_tests++;
          if ({cdb_tag[i*TW +: TW], cdb_result[i*XLEN +: XLEN], cdb_jump_addr[i*XLEN +: XLEN], cdb_mispredict[i]}
              !== {e.tag, e.res, e.jmp, e.mis}) begin
            n_fail++; $display("FAIL rand_data c%0d bus%0d: got tag=%0d res=%h jmp=%h mis=%b exp %0d %h %h %b",
                               c, i, cdb_tag[i*TW +: TW], cdb_result[i*XLEN +: XLEN],
                               cdb_jump_addr[i*XLEN +: XLEN], cdb_mispredict[i], e.tag, e.res, e.jmp, e.mis);
          end
        end
      end
      if (flush) q.delete();
      else begin
        for (int i = 0; i < pops; i++) void'(q.pop_front());
        if (feed_valid && exp_ready)
          q.push_back(model(feed_op, feed_rs1, feed_rs2, feed_pc, feed_imm, feed_tag, feed_pred_taken));
      end
      tick();
    end
    feed_valid = 1'b0; flush = 1'b0; cdb_grant = '0;
  endtask

  initial begin
    test_reset();
    test_beq();
    test_jalr();
    test_signed();
    test_full();
    test_prefix();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
